// File: rtl/butterfly_modred_if.sv
// rtl/butterfly_modred_if.sv - valid/ready bundle between the butterfly adder and write-back
interface butterfly_modred_if #(
  parameter int IN_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [11:0]     out_data;
  logic            out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/butterfly_modred.sv
// rtl/butterfly_modred.sv - four-stage Barrett reduction of the adder sum modulo q
module butterfly_modred #(
  parameter int IN_W = 32,
  parameter int Q    = 3329,
  parameter int K    = 24,
  parameter int M    = 5039
) (
  input  logic               clk,
  input  logic               rst,
  butterfly_modred_if.slave  bus
);
  localparam logic [13:0] Q1 = 14'(Q);
  localparam logic [13:0] Q2 = 14'(2 * Q);

  logic         adv;

  logic         s1_valid;
  logic [K-1:0] s1_x;
  logic         s1_err;

  logic         s2_valid;
  logic [12:0]  s2_t;
  logic [K-1:0] s2_x;
  logic         s2_err;

  logic         s3_valid;
  logic [13:0]  s3_r;
  logic         s3_err;

  logic         s4_valid;
  logic [11:0]  s4_data;
  logic         s4_err;

  logic [12:0]  t_next;
  logic [13:0]  r_next;
  logic [11:0]  y_next;

  // Whole pipe moves as one; a stalled output freezes every stage.
  assign adv          = ~s4_valid | bus.out_ready;
  assign bus.in_ready = adv & ~rst;

  always_comb begin
    t_next = 13'((37'(s1_x) * 37'(M)) >> K);
    // True remainder fits in 14 bits, so modulo-2^14 arithmetic is exact.
    r_next = 14'(s2_x) - 14'(26'(s2_t) * 26'(Q));
    if (s3_r >= Q2) begin
      y_next = 12'(s3_r - Q2);
    end else if (s3_r >= Q1) begin
      y_next = 12'(s3_r - Q1);
    end else begin
      y_next = 12'(s3_r);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_err   <= 1'b0;
      s2_valid <= 1'b0;
      s2_t     <= '0;
      s2_x     <= '0;
      s2_err   <= 1'b0;
      s3_valid <= 1'b0;
      s3_r     <= '0;
      s3_err   <= 1'b0;
      s4_valid <= 1'b0;
      s4_data  <= '0;
      s4_err   <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_x     <= bus.in_data[K-1:0];
      s1_err   <= |bus.in_data[IN_W-1:K];
      s2_valid <= s1_valid;
      s2_t     <= t_next;
      s2_x     <= s1_x;
      s2_err   <= s1_err;
      s3_valid <= s2_valid;
      s3_r     <= r_next;
      s3_err   <= s2_err;
      s4_valid <= s3_valid;
      s4_data  <= y_next;
      s4_err   <= s3_err;
    end
  end

  assign bus.out_valid = s4_valid;
  assign bus.out_data  = s4_data;
  assign bus.out_err   = s4_err;
endmodule

// File: tb/tb_butterfly_modred.sv
// tb/tb_butterfly_modred.sv - directed-vector bench for butterfly_modred
module tb_butterfly_modred;
  logic clk = 1'b0;
  logic rst = 1'b1;

  butterfly_modred_if #(.IN_W(32)) bus ();

  butterfly_modred #(.IN_W(32), .Q(3329), .K(24), .M(5039)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        bp = 1'b0;
  logic        chk_lat = 1'b1;
  logic [12:0] exp_q[$];
  int          acc_q[$];
  int          out_cyc_q[$];
  logic        prev_stall = 1'b0;
  logic [12:0] prev_out = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [12:0] e;
    int          a;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (prev_stall) check("stall_hold", 32'({bus.out_err, bus.out_data}), 32'(prev_out));
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (bus.out_valid && bus.out_ready) begin
        out_cyc_q.push_back(cyc);
        check("expected_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e[11:0]));
          check("out_err", 32'(bus.out_err), 32'(e[12]));
        end
        if (acc_q.size() > 0) begin
          a = acc_q.pop_front();
          if (chk_lat) check("latency", 32'(cyc - a), 32'd4);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_err, bus.out_data};
    end
  end

  task automatic send(input logic [31:0] d, input logic [12:0] e);
    int   n = 0;
    logic acc;
    exp_q.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    do begin
      if (bp) bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      if (bp) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [31:0] vec_in  [9] = '{32'd0, 32'd3328, 32'd3329, 32'd6658, 32'd9986,
                               32'd11078912, 32'd16777215, 32'h01000005, 32'd7};
  logic [12:0] vec_exp [9] = '{13'd0, 13'd3328, 13'd0, 13'd0, 13'd3328,
                               13'd0, 13'd2384, {1'b1, 12'd5}, 13'd7};

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] x;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single directed samples, each drained before the next.
    for (int i = 0; i < 9; i++) begin
      send(vec_in[i], vec_exp[i]);
      drain();
    end

    // Random reduction against a mod-3329 reference, back to back.
    for (int i = 0; i < 2000; i++) begin
      x = 32'($urandom_range(0, 24'hFFFFFF));
      send(x, {1'b0, 12'(x % 32'd3329)});
    end
    drain();

    // Back-pressure: stream 0..19 with random out_ready.
    bp = 1'b1;
    chk_lat = 1'b0;
    for (int i = 0; i < 20; i++) send(32'(i), 13'(i));
    drain();
    bp = 1'b0;
    chk_lat = 1'b1;

    // Throughput: 100 back-to-back samples with no gaps.
    out_cyc_q.delete();
    for (int i = 0; i < 100; i++) send(32'(i * 331), 13'((i * 331) % 3329));
    drain();
    check("tput_count", 32'(out_cyc_q.size()), 32'd100);
    if (out_cyc_q.size() == 100) check("tput_span", 32'(out_cyc_q[99] - out_cyc_q[0]), 32'd99);

    // Reset with the pipe full.
    for (int i = 0; i < 5; i++) send(32'(1000 + i), 13'(1000 + i));
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_drop_valid", 32'(bus.out_valid), 32'd0);
    check("rst_drop_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_cyc_q.delete();
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_out", 32'(out_cyc_q.size()), 32'd0);
    send(32'd3430, 13'd101);
    drain();
    check("post_rst_count", 32'(out_cyc_q.size()), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
